// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
// Address and data widths match the 32x32 register file it drives.
package regfile_pkg;

   localparam int RF_AW = 5;
   localparam int RF_DW = 32;
   localparam int NREG  = 32;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_COPY  = 2'b10,
      OP_CLEAR = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RSP,
      S_CP_RD,
      S_CP_WR,
      S_CLR
   } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the register file's write and read ports.
// Handles WRITE, READ, COPY and CLEAR. READ results go out through a valid/ready response.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int AW = RF_AW,
   parameter int DW = RF_DW,
   parameter logic [DW-1:0] CLEAR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_src,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data1,
   output logic [DW-1:0] rsp_data2,
   output logic          rf_we3,
   output logic [AW-1:0] rf_wa3,
   output logic [DW-1:0] rf_wd3,
   output logic [AW-1:0] rf_ra1,
   output logic [AW-1:0] rf_ra2,
   input  logic [DW-1:0] rf_rd1,
   input  logic [DW-1:0] rf_rd2
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
   localparam logic [AW-1:0] FIRST_IDX = AW'(1);

   state_t        state_reg, state_next;
   logic          cmd_ready_reg;
   logic [AW-1:0] addr_reg, src_reg, cnt_reg;
   logic [DW-1:0] data_reg, copy_reg, rsp_data1_reg, rsp_data2_reg;
   logic          accept;

   assign accept    = (state_reg == S_IDLE) && cmd_valid && cmd_ready_reg;
   assign cmd_ready = cmd_ready_reg;
   assign rsp_valid = (state_reg == S_RSP);
   assign rsp_data1 = rsp_data1_reg;
   assign rsp_data2 = rsp_data2_reg;

   // Port outputs depend only on registered state; cmd_* affects only the next state.
   always_comb begin
      state_next = state_reg;
      rf_we3     = 1'b0;
      rf_wa3     = '0;
      rf_wd3     = '0;
      rf_ra1     = '0;
      rf_ra2     = '0;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               case (op_t'(cmd_op))
                  OP_WRITE: state_next = S_WR;
                  OP_READ:  state_next = S_RD;
                  OP_COPY:  state_next = S_CP_RD;
                  OP_CLEAR: state_next = S_CLR;
                  default:  state_next = S_IDLE;
               endcase
            end
         end
         S_WR: begin
            rf_we3     = (addr_reg != '0);
            rf_wa3     = addr_reg;
            rf_wd3     = data_reg;
            state_next = S_IDLE;
         end
         S_RD: begin
            rf_ra1     = addr_reg;
            rf_ra2     = src_reg;
            state_next = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready) state_next = S_IDLE;
         end
         S_CP_RD: begin
            rf_ra1     = src_reg;
            state_next = S_CP_WR;
         end
         S_CP_WR: begin
            rf_we3     = (addr_reg != '0);
            rf_wa3     = addr_reg;
            rf_wd3     = copy_reg;
            state_next = S_IDLE;
         end
         S_CLR: begin
            rf_we3 = 1'b1;
            rf_wa3 = cnt_reg;
            rf_wd3 = CLEAR_VAL;
            if (cnt_reg == LAST_IDX) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A registered ready keeps cmd_ready low through reset and for the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cmd_ready_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cmd_ready_reg <= (state_next == S_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg      <= '0;
         src_reg       <= '0;
         data_reg      <= '0;
         copy_reg      <= '0;
         cnt_reg       <= FIRST_IDX;
         rsp_data1_reg <= '0;
         rsp_data2_reg <= '0;
      end else begin
         if (accept) begin
            addr_reg <= cmd_addr;
            src_reg  <= cmd_src;
            data_reg <= cmd_data;
         end
         if (state_reg == S_RD) begin
            rsp_data1_reg <= rf_rd1;
            rsp_data2_reg <= rf_rd2;
         end
         if (state_reg == S_CP_RD) copy_reg <= rf_rd1;
         if (state_reg == S_CLR) cnt_reg <= (cnt_reg == LAST_IDX) ? FIRST_IDX : cnt_reg + FIRST_IDX;
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file acts as the responder.
// The register contents are predicted at command level in ref_mem.
module tb_regfile_access_ctrl;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_addr = '0;
   logic [4:0]  cmd_src = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data1, rsp_data2;
   logic        rf_we3;
   logic [4:0]  rf_wa3, rf_ra1, rf_ra2;
   logic [31:0] rf_wd3, rf_rd1, rf_rd2;

   int errors = 0;
   int checks = 0;

   logic [31:0] rf_mem  [32];
   logic [31:0] ref_mem [32];

   always #5 clk = ~clk;

   regfile_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
      .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
   );

   // Responder: R0 reads as zero and ignores writes
   always @(posedge clk) if (rf_we3 && rf_wa3 != 5'd0) rf_mem[rf_wa3] <= rf_wd3;
   assign rf_rd1 = (rf_ra1 == 5'd0) ? 32'd0 : rf_mem[rf_ra1];
   assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'd0 : rf_mem[rf_ra2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for cmd_ready and completes the handshake. Returns 1 ns into cycle N+1.
   task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] s,
                        input logic [31:0] d);
      int n = 0;
      $display("txn op=%0d addr=%0d src=%0d data=%08h", op, a, s, d);
      cmd_op = op; cmd_addr = a; cmd_src = s; cmd_data = d; cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL issue_timeout cmd_ready=%b required 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_addr = 5'($urandom); cmd_src = 5'($urandom); cmd_data = $urandom;
   endtask

   task automatic do_read(input logic [4:0] a, input logic [4:0] s, input int hold,
                          output logic [31:0] d1, output logic [31:0] d2,
                          output logic lat_ok, output logic stable_ok, output logic post_ok);
      issue(OP_READ, a, s, 32'd0);
      lat_ok = (rsp_valid === 1'b0) && (rf_ra1 === a) && (rf_ra2 === s) && (rf_we3 === 1'b0);
      tick();
      lat_ok = lat_ok && (rsp_valid === 1'b1);
      d1 = rsp_data1; d2 = rsp_data2; stable_ok = 1'b1;
      repeat (hold) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data1 !== d1 || rsp_data2 !== d2 || cmd_ready !== 1'b0)
            stable_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      post_ok = (rsp_valid === 1'b0) && (cmd_ready === 1'b1) && (rsp_data1 === d1) && (rsp_data2 === d2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({cmd_ready, rsp_valid, rf_we3, rf_wa3, rf_wd3, rf_ra1, rf_ra2, rsp_data1, rsp_data2} !== '0) begin
         errors++;
         $display("FAIL reset_outputs ready=%b valid=%b we3=%b wa3=%0d wd3=%h ra1=%0d ra2=%0d d1=%h d2=%h required all 0",
                  cmd_ready, rsp_valid, rf_we3, rf_wa3, rf_wd3, rf_ra1, rf_ra2, rsp_data1, rsp_data2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready cmd_ready=%b required 0 before first edge", cmd_ready);
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_edge_ready cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] d1, d2;
      logic lat_ok, stable_ok, post_ok;
      issue(OP_WRITE, 5'd5, 5'd0, 32'hA5A5A5A5);
      checks++;
      if ({rf_we3, rf_wa3, rf_wd3, cmd_ready} !== {1'b1, 5'd5, 32'hA5A5A5A5, 1'b0}) begin
         errors++;
         $display("FAIL write_pulse we3=%b wa3=%0d wd3=%h ready=%b required 1/5/a5a5a5a5/0",
                  rf_we3, rf_wa3, rf_wd3, cmd_ready);
      end
      ref_mem[5] = 32'hA5A5A5A5;
      tick();
      checks++;
      if (rf_we3 !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_end we3=%b ready=%b required 0/1", rf_we3, cmd_ready);
      end
      do_read(5'd5, 5'd0, 0, d1, d2, lat_ok, stable_ok, post_ok);
      checks++;
      if (d1 !== ref_mem[5] || d2 !== 32'd0) begin
         errors++;
         $display("FAIL read_5_0 got=%h/%h required %h/00000000", d1, d2, ref_mem[5]);
      end
      checks++;
      if (!lat_ok || !post_ok) begin
         errors++;
         $display("FAIL read_timing lat_ok=%b post_ok=%b required 1/1", lat_ok, post_ok);
      end
   endtask

   task automatic test_write_zero();
      logic [31:0] d1, d2;
      logic lat_ok, stable_ok, post_ok;
      issue(OP_WRITE, 5'd0, 5'd0, 32'hFFFFFFFF);
      checks++;
      if (rf_we3 !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_r0_we3 we3=%b ready=%b required 0/0", rf_we3, cmd_ready);
      end
      tick();
      checks++;
      if (rf_we3 !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_r0_end we3=%b ready=%b required 0/1", rf_we3, cmd_ready);
      end
      do_read(5'd0, 5'd5, 0, d1, d2, lat_ok, stable_ok, post_ok);
      checks++;
      if (d1 !== 32'd0 || d2 !== ref_mem[5] || !lat_ok || !post_ok) begin
         errors++;
         $display("FAIL read_0_5 got=%h/%h lat=%b post=%b required 00000000/%h/1/1",
                  d1, d2, lat_ok, post_ok, ref_mem[5]);
      end
   endtask

   task automatic test_copy();
      logic [31:0] d1, d2;
      logic lat_ok, stable_ok, post_ok;
      issue(OP_WRITE, 5'd10, 5'd0, 32'h12345678);
      ref_mem[10] = 32'h12345678;
      issue(OP_COPY, 5'd15, 5'd10, 32'hDEADBEEF);
      checks++;
      if (rf_we3 !== 1'b0 || rf_ra1 !== 5'd10) begin
         errors++;
         $display("FAIL copy_read_phase we3=%b ra1=%0d required 0/10", rf_we3, rf_ra1);
      end
      tick();
      checks++;
      if ({rf_we3, rf_wa3, rf_wd3, cmd_ready} !== {1'b1, 5'd15, 32'h12345678, 1'b0}) begin
         errors++;
         $display("FAIL copy_write_phase we3=%b wa3=%0d wd3=%h ready=%b required 1/15/12345678/0",
                  rf_we3, rf_wa3, rf_wd3, cmd_ready);
      end
      ref_mem[15] = ref_mem[10];
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || rf_we3 !== 1'b0) begin
         errors++;
         $display("FAIL copy_end ready=%b we3=%b required 1/0", cmd_ready, rf_we3);
      end
      do_read(5'd15, 5'd10, 0, d1, d2, lat_ok, stable_ok, post_ok);
      checks++;
      if (d1 !== ref_mem[15] || d2 !== ref_mem[10] || !lat_ok || !post_ok) begin
         errors++;
         $display("FAIL read_15_10 got=%h/%h required %h/%h", d1, d2, ref_mem[15], ref_mem[10]);
      end
      // COPY onto itself and COPY to R0
      issue(OP_COPY, 5'd15, 5'd15, 32'd0);
      tick();
      checks++;
      if ({rf_we3, rf_wa3, rf_wd3} !== {1'b1, 5'd15, ref_mem[15]}) begin
         errors++;
         $display("FAIL copy_self we3=%b wa3=%0d wd3=%h required 1/15/%h", rf_we3, rf_wa3, rf_wd3, ref_mem[15]);
      end
      issue(OP_COPY, 5'd0, 5'd10, 32'd0);
      tick();
      checks++;
      if (rf_we3 !== 1'b0) begin
         errors++;
         $display("FAIL copy_to_r0 we3=%b required 0", rf_we3);
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL copy_r0_end ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d1, d2;
      logic lat_ok, stable_ok, post_ok;
      do_read(5'd5, 5'd10, 5, d1, d2, lat_ok, stable_ok, post_ok);
      checks++;
      if (d1 !== ref_mem[5] || d2 !== ref_mem[10]) begin
         errors++;
         $display("FAIL bp_data got=%h/%h required %h/%h", d1, d2, ref_mem[5], ref_mem[10]);
      end
      checks++;
      if (!lat_ok || !stable_ok || !post_ok) begin
         errors++;
         $display("FAIL bp_hold lat=%b stable=%b post=%b required 1/1/1", lat_ok, stable_ok, post_ok);
      end
   endtask

   task automatic fill_all();
      for (int i = 1; i < 32; i++) begin
         logic [31:0] v;
         v = $urandom | 32'h1;
         issue(OP_WRITE, 5'(i), 5'd0, v);
         ref_mem[i] = v;
      end
   endtask

   task automatic test_clear();
      logic [31:0] d1, d2;
      logic lat_ok, stable_ok, post_ok;
      fill_all();
      issue(OP_CLEAR, 5'd0, 5'd0, 32'd0);
      for (int k = 1; k < 32; k++) begin
         checks++;
         if ({rf_we3, rf_wa3, rf_wd3, cmd_ready} !== {1'b1, 5'(k), 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL clear_seq k=%0d we3=%b wa3=%0d wd3=%h ready=%b required 1/%0d/0/0",
                     k, rf_we3, rf_wa3, rf_wd3, cmd_ready, k);
         end
         tick();
      end
      checks++;
      if (cmd_ready !== 1'b1 || rf_we3 !== 1'b0) begin
         errors++;
         $display("FAIL clear_end ready=%b we3=%b required 1/0", cmd_ready, rf_we3);
      end
      for (int i = 1; i < 32; i++) ref_mem[i] = 32'd0;
      for (int i = 0; i < 16; i++) begin
         do_read(5'(2 * i), 5'(2 * i + 1), 0, d1, d2, lat_ok, stable_ok, post_ok);
         checks++;
         if (d1 !== ref_mem[2 * i] || d2 !== ref_mem[2 * i + 1] || !lat_ok || !post_ok) begin
            errors++;
            $display("FAIL clear_read r%0d/r%0d got=%h/%h required 0/0", 2 * i, 2 * i + 1, d1, d2);
         end
      end
   endtask

   task automatic test_clear_reset();
      logic [31:0] d1, d2;
      logic lat_ok, stable_ok, post_ok;
      fill_all();
      issue(OP_CLEAR, 5'd0, 5'd0, 32'd0);
      repeat (9) tick();
      checks++;
      if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd10) begin
         errors++;
         $display("FAIL clear_10th we3=%b wa3=%0d required 1/10", rf_we3, rf_wa3);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, rf_we3, rf_wa3, rf_wd3, rf_ra1, rf_ra2} !== '0) begin
         errors++;
         $display("FAIL clear_abort_outputs ready=%b valid=%b we3=%b wa3=%0d wd3=%h required all 0",
                  cmd_ready, rsp_valid, rf_we3, rf_wa3, rf_wd3);
      end
      for (int i = 1; i < 10; i++) ref_mem[i] = 32'd0;
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_read(5'd9, 5'd10, 0, d1, d2, lat_ok, stable_ok, post_ok);
      checks++;
      if (d1 !== ref_mem[9] || d2 !== ref_mem[10]) begin
         errors++;
         $display("FAIL clear_partial got=%h/%h required %h/%h", d1, d2, ref_mem[9], ref_mem[10]);
      end
      issue(OP_CLEAR, 5'd0, 5'd0, 32'd0);
      for (int k = 1; k < 32; k++) begin
         checks++;
         if (rf_we3 !== 1'b1 || rf_wa3 !== 5'(k)) begin
            errors++;
            $display("FAIL clear_restart k=%0d we3=%b wa3=%0d required 1/%0d", k, rf_we3, rf_wa3, k);
         end
         tick();
      end
      for (int i = 1; i < 32; i++) ref_mem[i] = 32'd0;
      do_read(5'd10, 5'd31, 0, d1, d2, lat_ok, stable_ok, post_ok);
      checks++;
      if (d1 !== 32'd0 || d2 !== 32'd0 || !lat_ok || !post_ok) begin
         errors++;
         $display("FAIL clear_restart_read got=%h/%h required 0/0", d1, d2);
      end
   endtask

   task automatic test_random();
      logic [31:0] d1, d2, dd;
      logic lat_ok, stable_ok, post_ok;
      logic [4:0] a, s;
      int op, hold;
      for (int t = 0; t < 60; t++) begin
         op = $urandom_range(0, 2);
         a  = 5'($urandom);
         s  = 5'($urandom);
         dd = $urandom;
         if (op == 0) begin
            issue(OP_WRITE, a, s, dd);
            checks++;
            if (rf_we3 !== (a != 5'd0) || (a != 5'd0 && (rf_wa3 !== a || rf_wd3 !== dd))) begin
               errors++;
               $display("FAIL rnd_write we3=%b wa3=%0d wd3=%h required %b/%0d/%h", rf_we3, rf_wa3, rf_wd3, a != 5'd0, a, dd);
            end
            if (a != 5'd0) ref_mem[a] = dd;
            tick();
            checks++;
            if (cmd_ready !== 1'b1) begin
               errors++;
               $display("FAIL rnd_write_ready ready=%b required 1", cmd_ready);
            end
         end else if (op == 2) begin
            issue(OP_COPY, a, s, dd);
            tick();
            checks++;
            if (rf_we3 !== (a != 5'd0) || (a != 5'd0 && (rf_wa3 !== a || rf_wd3 !== ref_mem[s]))) begin
               errors++;
               $display("FAIL rnd_copy we3=%b wa3=%0d wd3=%h required %b/%0d/%h", rf_we3, rf_wa3, rf_wd3, a != 5'd0, a, ref_mem[s]);
            end
            if (a != 5'd0) ref_mem[a] = ref_mem[s];
            tick();
            checks++;
            if (cmd_ready !== 1'b1) begin
               errors++;
               $display("FAIL rnd_copy_ready ready=%b required 1", cmd_ready);
            end
         end else begin
            hold = $urandom_range(0, 3);
            do_read(a, s, hold, d1, d2, lat_ok, stable_ok, post_ok);
            checks++;
            if (d1 !== ref_mem[a] || d2 !== ref_mem[s] || !lat_ok || !stable_ok || !post_ok) begin
               errors++;
               $display("FAIL rnd_read r%0d/r%0d got=%h/%h required %h/%h lat=%b stable=%b post=%b",
                        a, s, d1, d2, ref_mem[a], ref_mem[s], lat_ok, stable_ok, post_ok);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
      test_reset();
      test_write_read();
      test_write_zero();
      test_copy();
      test_backpressure();
      test_clear();
      test_clear_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
